// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall encodings,
// MIPS exception codes, controller state and small decode helpers.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TR      = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    // The most downstream requester freezes itself and everything upstream of it.
    function automatic logic [5:0] stall_merge(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
        logic [5:0] v;
        if (req_mem) begin
            v = STALL_MEM;
        end else if (req_ex) begin
            v = STALL_EX;
        end else if (req_id) begin
            v = STALL_ID;
        end else if (req_if) begin
            v = STALL_IF;
        end else begin
            v = STALL_NONE;
        end
        return v;
    endfunction

    function automatic logic [31:0] exc_target(input logic [31:0] code, input logic [31:0] epc,
                                               input logic [31:0] vec);
        logic [31:0] t;
        if (code == EXC_ERET) begin
            t = epc;
        end else begin
            t = vec;
        end
        return t;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: merges stage stall requests and sequences
// exception/ERET entry (freeze, drain outstanding AXI traffic, one-cycle flush).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          DRAIN_MAX  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] epc_i,
    input  logic        ibus_busy,
    input  logic        dbus_busy,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        drain_timeout
);

    localparam int               CNT_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pipe_state_e      state_r;
    pipe_state_e      next_state_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_next_s;
    logic [CNT_W-1:0] drain_cnt_r;
    logic             drain_timeout_r;
    logic             flush_r;
    logic [31:0]      new_pc_r;
    logic [5:0]       stall_s;
    logic             exc_s;
    logic             bus_busy_s;
    logic             drain_limit_s;
    logic             accept_s;

    assign exc_s         = (excepttype_i != EXC_NONE);
    assign bus_busy_s    = ibus_busy | dbus_busy;
    assign drain_limit_s = (drain_cnt_r == CNT_LAST);
    assign accept_s      = (state_r == ST_IDLE) && exc_s;
    // The target is captured only on acceptance; later code/EPC changes are ignored.
    assign pc_next_s     = accept_s ? exc_target(excepttype_i, epc_i, EXC_VECTOR) : pc_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (exc_s) begin
                    next_state_s = bus_busy_s ? ST_DRAIN : ST_FLUSH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!bus_busy_s || drain_limit_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_FLUSH: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Target latch, drain counter, sticky timeout and registered flush/new_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r            <= 32'h0000_0000;
            drain_cnt_r     <= '0;
            drain_timeout_r <= 1'b0;
            flush_r         <= 1'b0;
            new_pc_r        <= 32'h0000_0000;
        end else begin
            pc_r     <= pc_next_s;
            flush_r  <= (next_state_s == ST_FLUSH);
            new_pc_r <= (next_state_s == ST_FLUSH) ? pc_next_s : 32'h0000_0000;
            if (accept_s) begin
                drain_cnt_r <= '0;
            end else if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + CNT_ONE;
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end
            // A normal exit in the limit cycle takes precedence over the timeout.
            if ((state_r == ST_DRAIN) && bus_busy_s && drain_limit_s) begin
                drain_timeout_r <= 1'b1;
            end else begin
                drain_timeout_r <= drain_timeout_r;
            end
        end
    end

    // Output decode: stall stays combinational for zero-latency response.
    always_comb begin
        stall_s = STALL_NONE;
        case (state_r)
            ST_IDLE: begin
                if (exc_s) begin
                    stall_s = STALL_MEM;
                end else begin
                    stall_s = stall_merge(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
                end
            end
            ST_DRAIN: stall_s = STALL_MEM;
            ST_FLUSH: stall_s = STALL_NONE;
            default:  stall_s = STALL_NONE;
        endcase
    end

    assign stall         = stall_s;
    assign flush         = flush_r;
    assign new_pc        = new_pc_r;
    assign drain_timeout = drain_timeout_r;

endmodule
